jt08_adpcm_enca: RTL
====================

# jt08_adpcm_encA

ADPCM-A encoder: converts a stream of 16-bit signed PCM samples into the 4-bit YM2610 ADPCM-A nibble stream that the ADPCM-A channel decoder consumes, packed two nibbles per byte. The predictor and step-index tracking mirror the decoder bit-for-bit, so encoded data replays exactly as the encoder modelled it. It sits on the tooling/loader side, feeding the sample-ROM writer. Each output byte is a ROM byte, and the byte counter gives the END address.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only when high
- clr  in  1  restart stream: acc=0, idx=0, partial nibble flushed, byte_cnt=0
- pcm_in  in  16  signed sample; only pcm_in[15:4] (12-bit target) is used
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted when in_valid&in_ready&cen
- byte_out  out  8  packed data; first nibble in [7:4], second in [3:0]
- out_valid  out  1  byte_out valid
- out_ready  in  1  byte consumed when out_valid&out_ready&cen
- byte_cnt  out  20  bytes emitted since clr; top 12 bits = END register value

## Operation
- State: acc (12-bit signed), idx (0..48), half (nibble pending), hi (stored high nibble).
- Tables: step[49] = 16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552. adj[m] = -1,-1,-1,-1,2,5,7,9.
- FSM states and transitions:
  - IDLE -> DIFF on accept.
  - DIFF: diff = target - acc (13-bit); sign = diff<0; mag = |diff|.
  - SRCH: 3 cycles, binary search MSB first; m = largest 0..7 with (m*step)>>2 <= mag.
  - FIX: delta = ((2m+1)*step)>>3; next = sign ? acc-delta : acc+delta.
    - If next leaves -2048..2047: decrement m, one per cycle.
    - If m=0 still wraps: invert sign, then go to UPD.
  - UPD: nibble = {sign,m}; acc = next; idx = clamp(idx+adj[m], 0, 48).
    - If !half: hi = nibble, half = 1.
    - Else: byte_out = {hi,nibble}, out_valid = 1, half = 0, byte_cnt+1.
    - Then -> IDLE.
- in_ready = (state==IDLE) && !out_valid.
- clr:
  - Synchronous, gated by cen, highest priority.
  - If half=1: emit {hi,4'h0} as a final byte; it waits in out_valid if not consumed.
  - Then resets acc/idx/half/byte_cnt and returns to IDLE.
  - The flush byte is not counted.
- byte_cnt wraps 0xFFFFF -> 0.

## Timing
- Reset values: in_ready=0 during reset, 1 in the first cycle after release; out_valid=0; byte_out=0; byte_cnt=0; acc=0; idx=0; half=0; state IDLE.
- Per-sample latency in cen cycles: accept -> DIFF 1 -> SRCH 3 -> FIX 1+k (k = decrements) -> UPD 1. Minimum is 6 cen cycles from accept to nibble commit.
- Byte output:
  - out_valid rises the cycle after the second nibble's UPD.
  - It holds with byte_out stable until out_ready.
  - It falls the cycle after the handshake.
- Backpressure: while out_valid=1 no new sample is accepted, giving at most one byte in flight.
- Simultaneous clr and in_valid: clr wins; the sample is not accepted.
- Async reset mid-sample: the partial nibble and the sample in progress are discarded.

## Structure
- Package jt08_adpcm_pkg: step table, adj table, IDX_MAX=48, ACC_MIN/ACC_MAX, FSM state enum.
- Sub-module jt08_adpcm_step: registered step lookup from idx, 1-cycle latency, aligned with DIFF.
- The decoder can share the same package tables.

## Test plan
- clr, then samples 0x0000, 0x0000:
  - nibbles 0x0 (acc=2) then 0x8 (acc=0); byte_out=0x08; byte_cnt=1; idx stays 0.
- After clr, sample 0x7FF0:
  - m=7, nibble 0x7, acc=30, idx=9 (step 37).
- Hold 0x7FF0 for 200 samples: acc never exceeds 2047 and never wraps negative. A reference-model decoder fed byte_out reproduces the acc trace exactly.
- out_ready held low after a byte: in_ready stays 0, byte_out stable. Release out_ready: one handshake, then in_ready=1 next cycle.
- 3 samples then clr: the third nibble is flushed as {hi,0}; byte_cnt resets to 0; the next sample encodes from acc=0, idx=0.
- Random PCM with cen toggling 50% and random out_ready: the byte stream equals the bit-exact C model; reset asserted mid-SRCH returns all outputs to reset values.

Source files
------------

// File: rtl/jt08_adpcm_pkg.sv
// Shared constants for the YM2610 ADPCM-A encoder and decoder.
// Holds the step and index-adjust tables, accumulator limits, and FSM states.
package jt08_adpcm_pkg;

   localparam logic [5:0]        IDX_MAX = 6'd48;
   localparam logic signed [13:0] ACC_MIN = -14'sd2048;
   localparam logic signed [13:0] ACC_MAX = 14'sd2047;

   localparam logic [10:0] STEP_TAB [0:48] = '{
      11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
      11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
      11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
      11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
      11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
      11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
      11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
   };

   localparam logic signed [4:0] ADJ_TAB [0:7] = '{
      -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd5, 5'sd7, 5'sd9
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIFF,
      ST_SRCH,
      ST_FIX,
      ST_UPD
   } state_t;

   // Next step index after emitting magnitude m, clamped to the table range.
   function automatic logic [5:0] idx_adv(input logic [5:0] idx, input logic [2:0] m);
      logic [6:0] sum;
      sum = {1'b0, idx} + {{2{ADJ_TAB[m][4]}}, ADJ_TAB[m]};
      if (sum[6])
         return 6'd0;
      else if (sum[5:0] > IDX_MAX)
         return IDX_MAX;
      else
         return sum[5:0];
   endfunction

endpackage

// File: rtl/jt08_adpcm_step.sv
// Registered step-size lookup; one clock-enable of latency from idx to step.
module jt08_adpcm_step
   import jt08_adpcm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic [5:0]  idx,
   output logic [10:0] step
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         step <= STEP_TAB[0];
      else if (cen)
         step <= STEP_TAB[(idx > IDX_MAX) ? IDX_MAX : idx];
   end

endmodule

// File: rtl/jt08_adpcm_enca.sv
// ADPCM-A encoder: 12-bit PCM targets in, packed nibble pairs out.
// Predictor state matches the channel decoder exactly, so playback tracks acc.
module jt08_adpcm_enca
   import jt08_adpcm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cen,
   input  logic        clr,
   input  logic [15:0] pcm_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  byte_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [19:0] byte_cnt
);

   state_t             state;
   logic signed [11:0] target;
   logic signed [11:0] acc;
   logic [5:0]         idx;
   logic               half;
   logic [3:0]         hi;
   logic               sign;
   logic [12:0]        mag;
   logic [2:0]         m;
   logic [1:0]         cnt;
   logic [10:0]        step;

   logic signed [12:0] diff;
   logic [2:0]         trial;
   logic [13:0]        trial_prod;
   logic [14:0]        delta_prod;
   logic [11:0]        delta;
   logic signed [13:0] acc_ext;
   logic signed [13:0] delta_ext;
   logic signed [13:0] next_acc;
   logic               wraps;
   logic               unused_bits;

   jt08_adpcm_step u_step (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (cen),
      .idx   (idx),
      .step  (step)
   );

   assign in_ready = rst_n && (state == ST_IDLE) && !out_valid;

   always_comb begin
      diff       = {target[11], target} - {acc[11], acc};
      // Search one magnitude bit per cycle, MSB first.
      trial      = m | (3'b100 >> cnt);
      trial_prod = {11'd0, trial} * {3'd0, step};
      delta_prod = {11'd0, m, 1'b1} * {4'd0, step};
      delta      = delta_prod[14:3];
      acc_ext    = {{2{acc[11]}}, acc};
      delta_ext  = {2'b00, delta};
      next_acc   = sign ? (acc_ext - delta_ext) : (acc_ext + delta_ext);
      wraps      = (next_acc < ACC_MIN) || (next_acc > ACC_MAX);
   end

   assign unused_bits = ^{pcm_in[3:0], trial_prod[1:0], delta_prod[2:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         target    <= '0;
         acc       <= '0;
         idx       <= '0;
         half      <= 1'b0;
         hi        <= '0;
         sign      <= 1'b0;
         mag       <= '0;
         m         <= '0;
         cnt       <= '0;
         byte_out  <= '0;
         out_valid <= 1'b0;
         byte_cnt  <= '0;
      end else if (cen) begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (clr) begin
            // A pending high nibble leaves as a padded byte that is not counted.
            if (half) begin
               byte_out  <= {hi, 4'h0};
               out_valid <= 1'b1;
            end
            acc      <= '0;
            idx      <= '0;
            half     <= 1'b0;
            byte_cnt <= '0;
            state    <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (in_valid && in_ready) begin
                     target <= pcm_in[15:4];
                     state  <= ST_DIFF;
                  end
               end
               ST_DIFF: begin
                  sign  <= diff[12];
                  mag   <= diff[12] ? 13'(-diff) : 13'(diff);
                  m     <= '0;
                  cnt   <= '0;
                  state <= ST_SRCH;
               end
               ST_SRCH: begin
                  if ({1'b0, trial_prod[13:2]} <= mag)
                     m <= trial;
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd2)
                     state <= ST_FIX;
               end
               ST_FIX: begin
                  // Back off until the step stays in range; m=0 can only fit by turning around.
                  if (wraps) begin
                     if (m != 3'd0) begin
                        m <= m - 3'd1;
                     end else begin
                        sign  <= ~sign;
                        state <= ST_UPD;
                     end
                  end else begin
                     state <= ST_UPD;
                  end
               end
               ST_UPD: begin
                  acc <= next_acc[11:0];
                  idx <= idx_adv(idx, m);
                  if (!half) begin
                     hi   <= {sign, m};
                     half <= 1'b1;
                  end else begin
                     byte_out  <= {hi, sign, m};
                     out_valid <= 1'b1;
                     half      <= 1'b0;
                     byte_cnt  <= byte_cnt + 20'd1;
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
